// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the memory-stage DMEM port.
// Loads are combinational, stores commit at the clock edge, the RAM is zero-filled by a
// sweep after reset, and a tohost register latches the first halt store.
// Optional feature: define DMEM_CYCLE_CNT_EN to add a free-running cycle counter that is
// readable at CYCLE_ADDR once the sweep has finished.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0,
  parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        init_done,
  output logic        store_err,
  output logic [31:0] store_cnt,
  output logic        halt,
  output logic [31:0] tohost
);

  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clrIdx_q, clrIdx_d;
  logic             storeErr_q, storeErr_d;
  logic [31:0]      storeCnt_q, storeCnt_d;
  logic             halt_q, halt_d;
  logic [31:0]      tohost_q, tohost_d;

  // Single write port shared between the clearing sweep and pipeline stores.
  logic [31:0]      mem [DEPTH_WORDS];
  logic             memWe;
  logic [IDX_W-1:0] memIdx;
  logic [31:0]      memWdata;

  // Address decode of the incoming byte address.
  logic             inRange;
  logic             aligned;
  logic             tohostHit;
  logic             cycleHit;
  logic [IDX_W-1:0] wordIdx;

  assign inRange   = (dmem_addr[31:IDX_W+2] == '0);
  assign aligned   = (dmem_addr[1:0] == 2'b00);
  assign tohostHit = (dmem_addr == TOHOST_ADDR);
  assign cycleHit  = (dmem_addr == CYCLE_ADDR);
  assign wordIdx   = dmem_addr[IDX_W+1:2];

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycleCnt_q;

  // Free-running cycle counter: zero after reset, counts every cycle, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_q + 32'd1;
    end
  end
`endif

  // State and status registers; reset restarts the sweep and clears every status output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clrIdx_q   <= '0;
      storeErr_q <= 1'b0;
      storeCnt_q <= '0;
      halt_q     <= 1'b0;
      tohost_q   <= '0;
    end else begin
      state_q    <= state_d;
      clrIdx_q   <= clrIdx_d;
      storeErr_q <= storeErr_d;
      storeCnt_q <= storeCnt_d;
      halt_q     <= halt_d;
      tohost_q   <= tohost_d;
    end
  end

  // Next-state logic: the sweep owns the RAM port in CLEAR, pipeline stores own it in READY.
  always_comb begin
    state_d    = state_q;
    clrIdx_d   = clrIdx_q;
    storeErr_d = storeErr_q;
    storeCnt_d = storeCnt_q;
    halt_d     = halt_q;
    tohost_d   = tohost_q;
    memWe      = 1'b0;
    memIdx     = clrIdx_q;
    memWdata   = '0;

    unique case (state_q)
      CLEAR: begin
        memWe    = 1'b1;
        memIdx   = clrIdx_q;
        memWdata = '0;
        clrIdx_d = clrIdx_q + 1'b1;
        if (clrIdx_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      READY: begin
        if (dmem_we) begin
          if (aligned && inRange) begin
            memWe    = 1'b1;
            memIdx   = wordIdx;
            memWdata = dmem_wdata;
            if (storeCnt_q != 32'hFFFF_FFFF) begin
              storeCnt_d = storeCnt_q + 32'd1;
            end
          end else if (tohostHit) begin
            if (!halt_q) begin
              tohost_d = dmem_wdata;
              halt_d   = 1'b1;
            end
          end else begin
            storeErr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // RAM write port; contents are never reset directly, the sweep zero-fills them.
  always_ff @(posedge clk) begin
    if (memWe && !rst) begin
      mem[memIdx] <= memWdata;
    end
  end

  // Combinational load path: old word is visible during a same-address store.
  always_comb begin
    dmem_rdata = '0;
    if (state_q == READY) begin
      if (inRange) begin
        dmem_rdata = mem[wordIdx];
      end else if (tohostHit) begin
        dmem_rdata = tohost_q;
      end else if (cycleHit) begin
`ifdef DMEM_CYCLE_CNT_EN
        dmem_rdata = cycleCnt_q;
`else
        dmem_rdata = '0;
`endif
      end
    end
  end

  assign init_done = (state_q == READY);
  assign store_err = storeErr_q;
  assign store_cnt = storeCnt_q;
  assign halt      = halt_q;
  assign tohost    = tohost_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with DEPTH_WORDS=16.
// Stimulus pushes the expected outputs of each cycle into a queue; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_dmem_responder;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] TOHOST = 32'hFFFF_FFF0;
  localparam logic [31:0] CYCLE  = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        init_done;
  logic        store_err;
  logic [31:0] store_cnt;
  logic        halt;
  logic [31:0] tohost;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .TOHOST_ADDR(TOHOST),
    .CYCLE_ADDR (CYCLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .init_done (init_done),
    .store_err (store_err),
    .store_cnt (store_cnt),
    .halt      (halt),
    .tohost    (tohost)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    bit          check;
    logic [31:0] rdata;
    logic        initDone;
    logic        storeErr;
    logic [31:0] storeCnt;
    logic        halt;
    logic [31:0] tohost;
  } expT;

  expT sbQ[$];
  expT monExp;
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: memory as a plain array, readiness as "cycles since reset >= DEPTH".
  bit          mValid = 1'b0;
  int unsigned mSince = 0;
  logic [31:0] mMem [DEPTH];
  logic        mErr = 1'b0;
  logic        mHalt = 1'b0;
  logic [31:0] mCnt = '0;
  logic [31:0] mTohost = '0;

  function automatic bit modelReady();
    return mValid && (mSince >= DEPTH);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!modelReady()) return 32'h0;
    if (a < DEPTH * 4) return mMem[a / 4];
    if (a == TOHOST) return mTohost;
`ifdef DMEM_CYCLE_CNT_EN
    if (a == CYCLE) return mSince;
`endif
    return 32'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Drives one cycle of inputs, records the expected outputs, then advances the model over the edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [31:0] a,
                               input logic [31:0] d);
    expT e;
    @(posedge clk);
    #1;
    rst        = r;
    dmem_we    = we;
    dmem_addr  = a;
    dmem_wdata = d;
    e.check    = mValid;
    e.rdata    = modelRead(a);
    e.initDone = modelReady();
    e.storeErr = mErr;
    e.storeCnt = mCnt;
    e.halt     = mHalt;
    e.tohost   = mTohost;
    sbQ.push_back(e);
    if (r) begin
      mValid  = 1'b1;
      mSince  = 0;
      mErr    = 1'b0;
      mHalt   = 1'b0;
      mCnt    = '0;
      mTohost = '0;
      for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    end else if (mValid) begin
      if (modelReady() && we) begin
        if (a[1:0] == 2'b00 && a < DEPTH * 4) begin
          mMem[a / 4] = d;
          if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 32'd1;
        end else if (a == TOHOST) begin
          if (!mHalt) begin
            mTohost = d;
            mHalt   = 1'b1;
          end
        end else begin
          mErr = 1'b1;
        end
      end
      mSince++;
    end
  endtask

  // Monitor: compares the DUT's settled outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      monExp = sbQ.pop_front();
      if (monExp.check) begin
        checkOutput("rdata", dmem_rdata, monExp.rdata);
        checkOutput("init_done", {31'b0, init_done}, {31'b0, monExp.initDone});
        checkOutput("store_err", {31'b0, store_err}, {31'b0, monExp.storeErr});
        checkOutput("store_cnt", store_cnt, monExp.storeCnt);
        checkOutput("halt", {31'b0, halt}, {31'b0, monExp.halt});
        checkOutput("tohost", tohost, monExp.tohost);
      end
    end
  end

  logic [31:0] randAddr;
  int          drainWait;

  initial begin
    // Reset, then the sweep: sequential reads of every word and a store that must be ignored.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, (i == 2), 32'(i * 4), 32'hDEAD_BEEF);
    end
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0);

    // Store then load, including the same-cycle read of the old word.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);

    // Tohost: first store latches and halts, second is ignored without error.
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h0000_0001);
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h0000_0002);
    applyStimulus(1'b0, 1'b0, TOHOST, 32'h0);

    // Bad stores: misaligned and out of range, then a misaligned read of word 4.
    applyStimulus(1'b0, 1'b1, 32'h12, 32'hAAAA_5555);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h5555_AAAA);
    applyStimulus(1'b0, 1'b0, 32'h13, 32'h0);

    // Reset mid-operation; watch the cycle address through the sweep and beyond.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b0, CYCLE, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 1'b1, CYCLE, 32'h0000_0009);
    applyStimulus(1'b0, 1'b0, CYCLE, 32'h0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    randAddr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:       randAddr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        3:       randAddr = TOHOST;
        4:       randAddr = CYCLE;
        default: randAddr = $urandom | 32'h0000_0040;
      endcase
      applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), randAddr, $urandom);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    drainWait = 0;
    while (sbQ.size() > 0 && drainWait < 20) begin
      @(posedge clk);
      drainWait++;
    end
    if (sbQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
